fifo_rd_arbiter: RTL and testbench
==================================

# fifo_rd_arbiter

Round-robin read-port scheduler for the asynchronous FIFO read domain. It shares the single FIFO read port (rinc/empty/rdata) among NREQ consumers. Each granted consumer receives one uninterrupted burst of words tagged with its ID. The block sits in the read clock domain, between the read-pointer handler and the downstream consumers.

## Interface
- NREQ, 4, number of requesting consumers (≥2)
- DATA_W, 8, FIFO word width
- MAX_BURST, 8, maximum words per grant
- BURST_W, $clog2(MAX_BURST+1), width of one burst-length field
- ID_W, $clog2(NREQ), width of the destination ID
- i_rclk  input  1  read-domain clock; all logic on its rising edge
- i_rrst  input  1  reset, synchronous, active-high
- i_req  input  NREQ  per-consumer burst request, level
- i_burst_len  input  NREQ*BURST_W  requested length; field k is bits [k*BURST_W +: BURST_W]
- i_empty  input  1  FIFO empty flag from the read-pointer handler
- i_rdata  input  DATA_W  FIFO read data; valid one cycle after an accepted rinc
- o_rinc  output  1  FIFO read increment
- o_gnt  output  NREQ  one-hot grant, registered
- o_valid  output  1  o_data/o_dst_id valid
- o_data  output  DATA_W  delivered word
- o_dst_id  output  ID_W  index of the consumer owning o_data
- o_done  output  NREQ  one-cycle pulse on the consumer whose burst completed

## Operation
- Reset state:
  - FSM = IDLE, rr pointer = 0, burst count = 0.
  - o_gnt = 0, o_rinc = 0, o_valid = 0, o_data = 0, o_dst_id = 0, o_done = 0.
- FSM states are IDLE, BURST and TAIL.
- IDLE:
  - o_rinc = 0.
  - If any i_req bit is set, pick the winner by round-robin, searching from index rr upward with wrap.
  - Register o_gnt = one-hot(winner), register the winner ID, load the count with the clamped length, then go to BURST.
  - If no request is set, stay in IDLE.
- Length clamp: a requested length of 0 becomes 1; a length above MAX_BURST becomes MAX_BURST.
- BURST:
  - o_rinc = ~i_empty, combinational.
  - Each cycle with o_rinc = 1 decrements the count.
  - When the count is 1 and o_rinc = 1, go to TAIL.
  - While i_empty = 1, the block stalls in BURST indefinitely with o_rinc = 0 and the count held.
- TAIL:
  - o_rinc = 0.
  - Pulse o_done[winner].
  - Clear o_gnt and set rr = (winner+1) mod NREQ.
  - Return to IDLE.
- Data path:
  - o_valid is o_rinc registered.
  - o_data is i_rdata captured when o_valid is set; it holds its last value otherwise.
  - o_dst_id is the registered winner ID.
- A grant is committed once issued. Deasserting i_req mid-burst does not shorten the burst, and i_burst_len is sampled only in IDLE.
- Requests from non-granted consumers are ignored until the next IDLE.
- o_gnt is one-hot or zero at all times; at most one o_done bit is set at a time.
- i_rrst asserted in any state, including mid-burst:
  - Next cycle all outputs are at their reset values and rr = 0.
  - Any in-flight word is discarded.

## Timing
- Arbitration takes 1 cycle (the IDLE cycle in which requests are sampled). o_gnt rises at the end of it.
- First o_rinc can assert in the first BURST cycle, i.e. the 2nd cycle after i_req is sampled.
- Data latency: o_valid asserts 1 cycle after each o_rinc.
- With the FIFO never empty, a burst of L words occupies L+2 cycles: 1 IDLE, L BURST, 1 TAIL.
- The last o_valid and the o_done pulse occur in the same cycle (TAIL).
- Back-to-back grants: after TAIL, the next IDLE arbitrates with the updated rr. The minimum gap between bursts is 2 cycles with no o_valid (TAIL is not counted; it carries the last word).
- Reset takes effect on the first rising edge of i_rclk with i_rrst = 1.

## Test plan
- Single requester:
  - Stimulus: i_req = 4'b0001, len0 = 3, FIFO holds 5 words.
  - Required response: o_rinc high for exactly 3 cycles; o_valid for 3 cycles with o_dst_id = 0; o_done = 4'b0001 with the 3rd word; 2 words remain in the FIFO.
- Round-robin fairness:
  - Stimulus: i_req = 4'b1111 held, all lengths 2, FIFO never empty.
  - Required response: grant order 0,1,2,3,0; each burst is 4 cycles; o_gnt is always one-hot.
- Empty stall:
  - Stimulus: grant to requester 2 with len 4, i_empty = 1 after the 2nd word for 5 cycles, then deasserted.
  - Required response: o_rinc = 0 and the count is held during the stall; exactly 4 words total are delivered with ID 2; a single o_done[2] pulse.
- Length clamp:
  - Stimulus: len = 0 on requester 1, then len = 15 on requester 3, with MAX_BURST = 8.
  - Required response: requester 1 receives 1 word; requester 3 receives 8 words.
- Committed grant:
  - Stimulus: grant to requester 1 with len 5; i_req[1] dropped after the 1st word; i_burst_len changed mid-burst.
  - Required response: all 5 words are delivered to ID 1; the changes are ignored.
- Reset mid-burst:
  - Stimulus: i_rrst pulsed for 1 cycle during the 3rd BURST cycle.
  - Required response: the next cycle shows all outputs 0 and the FSM in IDLE; the following arbitration starts from requester 0.

Source files
------------

// File: rtl/fifo_rd_arbiter_if.sv
// Bundle of the FIFO read port and the consumer-side request/delivery signals
// shared between the read-domain arbiter (slave) and its environment (master).
interface fifo_rd_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8,
  parameter int BURST_W   = $clog2(MAX_BURST + 1),
  parameter int ID_W      = $clog2(NREQ)
) ();
  // Handshake: o_rinc pops one word only while i_empty is low; that word shows
  // up on i_rdata one cycle later, in the cycle o_valid qualifies o_data/o_dst_id.
  logic [NREQ-1:0]         i_req;
  logic [NREQ*BURST_W-1:0] i_burst_len;
  logic                    i_empty;
  logic [DATA_W-1:0]       i_rdata;
  logic                    o_rinc;
  logic [NREQ-1:0]         o_gnt;
  logic                    o_valid;
  logic [DATA_W-1:0]       o_data;
  logic [ID_W-1:0]         o_dst_id;
  logic [NREQ-1:0]         o_done;

  modport slave (
    input  i_req, i_burst_len, i_empty, i_rdata,
    output o_rinc, o_gnt, o_valid, o_data, o_dst_id, o_done
  );

  modport master (
    output i_req, i_burst_len, i_empty, i_rdata,
    input  o_rinc, o_gnt, o_valid, o_data, o_dst_id, o_done
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin scheduler sharing one FIFO read port among NREQ consumers; each
// grant delivers one uninterrupted, ID-tagged burst of clamped length.
module fifo_rd_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8,
  parameter int BURST_W   = $clog2(MAX_BURST + 1),
  parameter int ID_W      = $clog2(NREQ)
) (
  input  logic               i_rclk,
  input  logic               i_rrst,
  fifo_rd_arbiter_if.slave   bus,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    TAIL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [BURST_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   hold_q, hold_d;

  logic                rinc;
  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [ID_W:0]       cand;
  logic [BURST_W-1:0]  req_len;
  logic [BURST_W-1:0]  clamp_len;

  // Search upward from rr with wrap; the first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NREQ)) begin
        cand = cand - (ID_W+1)'(NREQ);
      end
      if (!win_found && bus.i_req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_len = bus.i_burst_len[win_idx*BURST_W +: BURST_W];
    if (req_len == '0) begin
      clamp_len = BURST_W'(1);
    end else if (req_len > BURST_W'(MAX_BURST)) begin
      clamp_len = BURST_W'(MAX_BURST);
    end else begin
      clamp_len = req_len;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    rinc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          id_d           = win_idx;
          cnt_d          = clamp_len;
          state_d        = BURST;
        end
      end
      BURST: begin
        rinc = ~bus.i_empty;
        if (rinc) begin
          cnt_d = cnt_q - BURST_W'(1);
          // done is registered so it lands in TAIL together with the last word.
          if (cnt_q == BURST_W'(1)) begin
            state_d      = TAIL;
            done_d[id_q] = 1'b1;
          end
        end
      end
      TAIL: begin
        gnt_d   = '0;
        rr_d    = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    valid_d = rinc;
    hold_d  = valid_q ? bus.i_rdata : hold_q;
  end

  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  // The FIFO word arrives in the o_valid cycle itself, so pass it through then.
  assign bus.o_data   = valid_q ? bus.i_rdata : hold_q;
  assign bus.o_rinc   = rinc;
  assign bus.o_gnt    = gnt_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_dst_id = id_q;
  assign bus.o_done   = done_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: a FIFO model feeds the read port while a
// transaction-level scoreboard predicts grant order, burst words and done pulses.
module tb_fifo_rd_arbiter;
  localparam int NREQ      = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 8;
  localparam int BURST_W   = $clog2(MAX_BURST + 1);
  localparam int ID_W      = $clog2(NREQ);
  localparam int W         = ID_W + DATA_W;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  fifo_rd_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) bus ();

  fifo_rd_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .i_rclk      (clk),
    .i_rrst      (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- model state / scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  int cyc = 0, rinc_cnt = 0, valid_cnt = 0, done_cnt = 0, burst_words = 0;
  int first_rinc_cyc = -1, last_done_cyc = -1, gnt_rise_cyc = 0;
  int rr_model = 0;
  bit gnt_rise = 0, stall = 0, rand_stall = 0, mon_en = 0;
  bit obs_rinc;
  logic [1:0]        obs_state;
  logic [NREQ-1:0]   prev_gnt = '0, gnt_rise_val = '0;
  logic [DATA_W-1:0] fifo_mem[$];
  logic [DATA_W-1:0] model_stream[$];
  logic [W-1:0]      exp_q[$];
  logic [ID_W-1:0]   exp_done_q[$];
  int                exp_len_q[$];

  function automatic int clamp_len(input int l);
    if (l == 0) return 1;
    if (l > MAX_BURST) return MAX_BURST;
    return l;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] req, input int rr);
    for (int i = 0; i < NREQ; i++) begin
      if (req[(rr + i) % NREQ]) return (rr + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic predict_burst(input logic [NREQ-1:0] req,
                               input logic [NREQ*BURST_W-1:0] lens, output int w);
    int l;
    w = rr_pick(req, rr_model);
    l = clamp_len(int'(lens[w*BURST_W +: BURST_W]));
    for (int i = 0; i < l; i++) exp_q.push_back({ID_W'(w), model_stream.pop_front()});
    exp_done_q.push_back(ID_W'(w));
    exp_len_q.push_back(l);
    rr_model = (w + 1) % NREQ;
  endtask

  task automatic push_words(input int n);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = DATA_W'($urandom);
      fifo_mem.push_back(d);
      model_stream.push_back(d);
    end
  endtask

  // One clock cycle: observe at negedge, apply FIFO pops just after posedge.
  task automatic tick();
    logic         pop;
    logic [W-1:0] e;
    logic [ID_W-1:0] id;
    int           l;
    if (rand_stall) stall = ($urandom_range(0, 3) == 0);
    bus.i_empty = stall || (fifo_mem.size() == 0);
    @(negedge clk);
    cyc++;
    pop       = bus.o_rinc;
    obs_rinc  = bus.o_rinc;
    obs_state = dbg_state;
    if (bus.o_rinc) begin
      rinc_cnt++;
      if (first_rinc_cyc < 0) first_rinc_cyc = cyc;
      tests_run++;
      if (bus.i_empty) begin
        tests_failed++;
        $display("FAIL rinc_while_empty: cycle %0d rinc=1 with empty=1", cyc);
      end
    end
    tests_run++;
    if (!$onehot0(bus.o_gnt) || !$onehot0(bus.o_done)) begin
      tests_failed++;
      $display("FAIL onehot: gnt=%b done=%b, required one-hot or zero", bus.o_gnt, bus.o_done);
    end
    if (mon_en && bus.o_valid) begin
      valid_cnt++;
      burst_words++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL data_unexpected: id=%0d data=%h, none expected", bus.o_dst_id, bus.o_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.o_dst_id, bus.o_data} !== e) begin
          tests_failed++;
          $display("FAIL data: got id=%0d data=%h, required id=%0d data=%h",
                   bus.o_dst_id, bus.o_data, e[W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
    if (mon_en && bus.o_done != '0) begin
      done_cnt++;
      last_done_cyc = cyc;
      tests_run++;
      if (exp_done_q.size() == 0) begin
        tests_failed++;
        $display("FAIL done_unexpected: done=%b", bus.o_done);
      end else begin
        id = exp_done_q.pop_front();
        l  = exp_len_q.pop_front();
        if (bus.o_done !== (NREQ'(1) << id) || bus.o_valid !== 1'b1 || burst_words != l) begin
          tests_failed++;
          $display("FAIL done: got done=%b valid=%b words=%0d, required done=%b valid=1 words=%0d",
                   bus.o_done, bus.o_valid, burst_words, NREQ'(1) << id, l);
        end
      end
      burst_words = 0;
    end
    if (prev_gnt == '0 && bus.o_gnt != '0) begin
      gnt_rise     = 1'b1;
      gnt_rise_val = bus.o_gnt;
      gnt_rise_cyc = cyc;
    end
    prev_gnt = bus.o_gnt;
    @(posedge clk);
    #1;
    if (pop && fifo_mem.size() > 0) bus.i_rdata = fifo_mem.pop_front();
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b1;
    mon_en = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    exp_q.delete();
    exp_done_q.delete();
    exp_len_q.delete();
    burst_words  = 0;
    rr_model     = 0;
    model_stream = fifo_mem;
  endtask

  task automatic wait_gnt(input int budget, output logic [NREQ-1:0] g);
    gnt_rise = 1'b0;
    g = '0;
    for (int i = 0; i < budget && !gnt_rise; i++) tick();
    if (gnt_rise) g = gnt_rise_val;
    else $display("FAIL gnt_timeout: no grant within %0d cycles", budget);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && exp_done_q.size() != 0; i++) tick();
    repeat (3) tick();
    tests_run++;
    if (exp_done_q.size() != 0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL done_timeout: %0d bursts and %0d words still outstanding, required 0",
               exp_done_q.size(), exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.i_req       = '1;
    bus.i_burst_len = '1;
    bus.i_rdata     = 8'hA5;
    do_reset(3);
    tests_run += 7;
    if (bus.o_gnt !== '0)    begin tests_failed++; $display("FAIL reset_gnt: got %b required 0", bus.o_gnt); end
    if (bus.o_rinc !== 1'b0) begin tests_failed++; $display("FAIL reset_rinc: got %b required 0", bus.o_rinc); end
    if (bus.o_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b required 0", bus.o_valid); end
    if (bus.o_data !== '0)   begin tests_failed++; $display("FAIL reset_data: got %h required 0", bus.o_data); end
    if (bus.o_dst_id !== '0) begin tests_failed++; $display("FAIL reset_dst_id: got %0d required 0", bus.o_dst_id); end
    if (bus.o_done !== '0)   begin tests_failed++; $display("FAIL reset_done: got %b required 0", bus.o_done); end
    if (dbg_state !== 2'd0)  begin tests_failed++; $display("FAIL reset_state: got %0d required IDLE(0)", dbg_state); end
    bus.i_req = '0;
    bus.i_burst_len = '0;
  endtask

  task automatic test_single_requester();
    logic [NREQ*BURST_W-1:0] lens = '0;
    logic [NREQ-1:0] g;
    int w, r0, v0, start;
    do_reset(2);
    push_words(5);
    lens[0 +: BURST_W] = BURST_W'(3);
    bus.i_burst_len = lens;
    r0 = rinc_cnt; v0 = valid_cnt; first_rinc_cyc = -1; start = cyc;
    bus.i_req = 4'b0001;
    predict_burst(bus.i_req, lens, w);
    wait_gnt(10, g);
    bus.i_req = '0;
    wait_done(40);
    tests_run += 6;
    if (g !== 4'b0001) begin tests_failed++; $display("FAIL single_gnt: got %b required 0001", g); end
    if (rinc_cnt - r0 != 3) begin tests_failed++; $display("FAIL single_rinc_cycles: got %0d required 3", rinc_cnt - r0); end
    if (valid_cnt - v0 != 3) begin tests_failed++; $display("FAIL single_valid_cycles: got %0d required 3", valid_cnt - v0); end
    if (first_rinc_cyc != start + 2) begin tests_failed++; $display("FAIL single_first_rinc: got cycle %0d required %0d", first_rinc_cyc - start, 2); end
    if (last_done_cyc != start + 5) begin tests_failed++; $display("FAIL single_done_cycle: got cycle %0d required %0d", last_done_cyc - start, 5); end
    if (fifo_mem.size() != 2) begin tests_failed++; $display("FAIL single_fifo_left: got %0d required 2", fifo_mem.size()); end
  endtask

  task automatic test_round_robin();
    logic [NREQ*BURST_W-1:0] lens;
    logic [NREQ-1:0] g;
    int w;
    int rise[5];
    do_reset(2);
    push_words(30);
    for (int k = 0; k < NREQ; k++) lens[k*BURST_W +: BURST_W] = BURST_W'(2);
    bus.i_burst_len = lens;
    bus.i_req = '1;
    for (int b = 0; b < 5; b++) begin
      predict_burst(bus.i_req, lens, w);
      wait_gnt(12, g);
      rise[b] = gnt_rise_cyc;
      tests_run++;
      if (g !== (NREQ'(1) << w)) begin
        tests_failed++;
        $display("FAIL rr_order burst %0d: got %b required %b", b, g, NREQ'(1) << w);
      end
    end
    bus.i_req = '0;
    wait_done(40);
    for (int b = 1; b < 5; b++) begin
      tests_run++;
      if (rise[b] - rise[b-1] != 4) begin
        tests_failed++;
        $display("FAIL rr_period burst %0d: got %0d cycles required 4", b, rise[b] - rise[b-1]);
      end
    end
  endtask

  task automatic test_empty_stall();
    logic [NREQ*BURST_W-1:0] lens = '0;
    logic [NREQ-1:0] g;
    int w, r0, v0, d0;
    do_reset(2);
    push_words(10);
    lens[2*BURST_W +: BURST_W] = BURST_W'(4);
    bus.i_burst_len = lens;
    r0 = rinc_cnt; v0 = valid_cnt; d0 = done_cnt;
    bus.i_req = 4'b0100;
    predict_burst(bus.i_req, lens, w);
    wait_gnt(10, g);
    bus.i_req = '0;
    for (int i = 0; i < 10 && rinc_cnt - r0 < 2; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (obs_rinc !== 1'b0 || obs_state !== 2'd1) begin
        tests_failed++;
        $display("FAIL stall cycle %0d: got rinc=%b state=%0d required rinc=0 state=BURST(1)", i, obs_rinc, obs_state);
      end
    end
    stall = 1'b0;
    wait_done(40);
    tests_run += 3;
    if (g !== 4'b0100) begin tests_failed++; $display("FAIL stall_gnt: got %b required 0100", g); end
    if (valid_cnt - v0 != 4) begin tests_failed++; $display("FAIL stall_words: got %0d required 4", valid_cnt - v0); end
    if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL stall_done_pulses: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_len_clamp();
    logic [NREQ*BURST_W-1:0] lens = '0;
    logic [NREQ-1:0] g;
    int w, v0;
    do_reset(2);
    push_words(20);
    lens[1*BURST_W +: BURST_W] = BURST_W'(0);
    lens[3*BURST_W +: BURST_W] = BURST_W'(15);
    bus.i_burst_len = lens;
    v0 = valid_cnt;
    bus.i_req = 4'b0010;
    predict_burst(bus.i_req, lens, w);
    wait_gnt(10, g);
    bus.i_req = '0;
    wait_done(30);
    tests_run++;
    if (valid_cnt - v0 != 1) begin tests_failed++; $display("FAIL clamp_zero: got %0d words required 1", valid_cnt - v0); end
    v0 = valid_cnt;
    bus.i_req = 4'b1000;
    predict_burst(bus.i_req, lens, w);
    wait_gnt(10, g);
    bus.i_req = '0;
    wait_done(40);
    tests_run++;
    if (valid_cnt - v0 != MAX_BURST) begin tests_failed++; $display("FAIL clamp_max: got %0d words required %0d", valid_cnt - v0, MAX_BURST); end
  endtask

  task automatic test_committed_grant();
    logic [NREQ*BURST_W-1:0] lens = '0;
    logic [NREQ-1:0] g;
    int w, v0;
    do_reset(2);
    push_words(12);
    lens[1*BURST_W +: BURST_W] = BURST_W'(5);
    bus.i_burst_len = lens;
    v0 = valid_cnt;
    bus.i_req = 4'b0010;
    predict_burst(bus.i_req, lens, w);
    wait_gnt(10, g);
    for (int i = 0; i < 10 && valid_cnt == v0; i++) tick();
    bus.i_req = '0;
    bus.i_burst_len = '1;
    wait_done(40);
    tests_run++;
    if (valid_cnt - v0 != 5) begin tests_failed++; $display("FAIL committed_words: got %0d required 5", valid_cnt - v0); end
    bus.i_burst_len = '0;
  endtask

  task automatic test_reset_mid_burst();
    logic [NREQ*BURST_W-1:0] lens = '0;
    logic [NREQ-1:0] g;
    int w;
    do_reset(2);
    push_words(20);
    lens[2*BURST_W +: BURST_W] = BURST_W'(2);
    lens[1*BURST_W +: BURST_W] = BURST_W'(6);
    bus.i_burst_len = lens;
    bus.i_req = 4'b0100;
    predict_burst(bus.i_req, lens, w);
    wait_gnt(10, g);
    bus.i_req = '0;
    wait_done(30);
    bus.i_req = 4'b0010;
    predict_burst(bus.i_req, lens, w);
    wait_gnt(10, g);
    bus.i_req = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run += 4;
    if (bus.o_gnt !== '0 || bus.o_rinc !== 1'b0 || bus.o_valid !== 1'b0)
      begin tests_failed++; $display("FAIL midrst_ctrl: got gnt=%b rinc=%b valid=%b required all 0", bus.o_gnt, bus.o_rinc, bus.o_valid); end
    if (bus.o_data !== '0 || bus.o_dst_id !== '0)
      begin tests_failed++; $display("FAIL midrst_data: got data=%h id=%0d required 0/0", bus.o_data, bus.o_dst_id); end
    if (bus.o_done !== '0) begin tests_failed++; $display("FAIL midrst_done: got %b required 0", bus.o_done); end
    if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL midrst_state: got %0d required IDLE(0)", dbg_state); end
    exp_q.delete();
    exp_done_q.delete();
    exp_len_q.delete();
    burst_words  = 0;
    rr_model     = 0;
    model_stream = fifo_mem;
    bus.i_req = '1;
    predict_burst(bus.i_req, lens, w);
    wait_gnt(10, g);
    bus.i_req = '0;
    tests_run++;
    if (g !== 4'b0001) begin tests_failed++; $display("FAIL midrst_rr_restart: got %b required 0001", g); end
    wait_done(40);
  endtask

  task automatic test_random();
    logic [NREQ*BURST_W-1:0] lens;
    logic [NREQ-1:0] g;
    int w;
    rand_stall = 1'b1;
    for (int it = 0; it < 12; it++) begin
      push_words(MAX_BURST + 2);
      lens = (NREQ*BURST_W)'($urandom);
      bus.i_burst_len = lens;
      bus.i_req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      predict_burst(bus.i_req, lens, w);
      wait_gnt(10, g);
      tests_run++;
      if (g !== (NREQ'(1) << w)) begin
        tests_failed++;
        $display("FAIL random_gnt iter %0d: got %b required %b", it, g, NREQ'(1) << w);
      end
      bus.i_req = '0;
      bus.i_burst_len = (NREQ*BURST_W)'($urandom);
      wait_done(200);
    end
    rand_stall = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    bus.i_req       = '0;
    bus.i_burst_len = '0;
    bus.i_empty     = 1'b1;
    bus.i_rdata     = '0;
    test_reset();
    test_single_requester();
    test_round_robin();
    test_empty_stall();
    test_len_clamp();
    test_committed_grant();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
